// File: rtl/mem_access_unit.sv
// Load/store access unit between EX/MEM and the data-side SRAM-like bus.
// One request register, an in-order FIFO of accepted ops, response dropping after flush.
module mem_access_unit #(
    parameter int DEPTH  = 2,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [3:0]        ex_op,
    input  logic [31:0]       ex_addr,
    input  logic [31:0]       ex_reg2,
    input  logic [REG_AW-1:0] ex_waddr,
    output logic              data_req,
    output logic              data_wr,
    output logic [3:0]        data_be,
    output logic [31:0]       data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_waddr,
    output logic [31:0]       wb_wdata,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic [31:0]       exc_badvaddr,
    output logic              busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [3:0] OP_LB  = 4'd0,  OP_LBU = 4'd1,  OP_LH  = 4'd2,  OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4,  OP_LWL = 4'd5,  OP_LWR = 4'd6,  OP_LL  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8,  OP_SH  = 4'd9,  OP_SW  = 4'd10, OP_SWL = 4'd11;
    localparam logic [3:0] OP_SWR = 4'd12;

    function automatic logic is_load(input logic [3:0] op);
        return op <= OP_LL;
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SWR);
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: return a[0];
            OP_LW, OP_LL, OP_SW:  return a != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] a);
        case (op)
            OP_SB:  return 4'b0001 << a;
            OP_SH:  return a[1] ? 4'b1100 : 4'b0011;
            OP_SWL: begin
                case (a)
                    2'd0:    return 4'b0001;
                    2'd1:    return 4'b0011;
                    2'd2:    return 4'b0111;
                    default: return 4'b1111;
                endcase
            end
            OP_SWR: return 4'b1111 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [1:0] a,
                                               input logic [31:0] r);
        case (op)
            OP_SB:  return {4{r[7:0]}};
            OP_SH:  return {2{r[15:0]}};
            OP_SWL: return r >> {~a, 3'b000};
            OP_SWR: return r << {a, 3'b000};
            default: return r;
        endcase
    endfunction

    function automatic logic [31:0] load_align(input logic [3:0] op, input logic [1:0] a,
                                               input logic [31:0] d, input logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = d[{a[1], 4'b0000} +: 16];
        case (op)
            OP_LB:  return {{24{b[7]}}, b};
            OP_LBU: return {24'h0, b};
            OP_LH:  return {{16{h[15]}}, h};
            OP_LHU: return {16'h0, h};
            OP_LW, OP_LL: return d;
            OP_LWL: begin
                case (a)
                    2'd0:    return {d[7:0],  r[23:0]};
                    2'd1:    return {d[15:0], r[15:0]};
                    2'd2:    return {d[23:0], r[7:0]};
                    default: return d;
                endcase
            end
            OP_LWR: begin
                case (a)
                    2'd0:    return d;
                    2'd1:    return {r[31:24], d[31:8]};
                    2'd2:    return {r[31:16], d[31:16]};
                    default: return {r[31:8],  d[31:24]};
                endcase
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Request register (p0): one op presented to the bus
    logic              req_r;
    logic [3:0]        req_op_p0;
    logic [1:0]        req_a_p0;
    logic [29:0]       req_word_p0;
    logic [31:0]       req_reg2_p0;
    logic [REG_AW-1:0] req_waddr_p0;
    logic              req_wr_p0;
    logic [3:0]        req_be_p0;
    logic [31:0]       req_wdata_p0;

    logic [3:0]        fifo_op    [DEPTH];
    logic [1:0]        fifo_a     [DEPTH];
    logic [31:0]       fifo_reg2  [DEPTH];
    logic [REG_AW-1:0] fifo_waddr [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [CW-1:0]     cnt, drop_cnt, cnt_n, drop_cnt_n;

    logic [CW:0] occ;
    logic        accept, issue, push, drop_now, pop, consume;
    logic [3:0]  head_op;
    logic [1:0]  head_a;

    assign occ      = (CW+1)'(cnt) + (CW+1)'(drop_cnt) + (CW+1)'(req_r);
    assign ex_ready = !flush && (!req_r || data_addr_ok) && (occ < (CW+1)'(DEPTH));
    assign accept   = ex_valid && ex_ready;
    assign issue    = accept && (is_load(ex_op) || is_store(ex_op)) && !misaligned(ex_op, ex_addr[1:0]);
    assign push     = req_r && data_addr_ok;
    assign drop_now = data_data_ok && (drop_cnt != '0);
    assign pop      = data_data_ok && (drop_cnt == '0) && (cnt != '0);
    assign consume  = drop_now || pop;
    assign head_op  = fifo_op[rd_ptr];
    assign head_a   = fifo_a[rd_ptr];

    always_comb begin
        cnt_n      = cnt;
        drop_cnt_n = drop_cnt;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        if (flush) begin
            // Everything still owed by the bus becomes a response to discard
            cnt_n      = '0;
            wr_ptr_n   = '0;
            rd_ptr_n   = '0;
            drop_cnt_n = CW'((CW+1)'(drop_cnt) + (CW+1)'(cnt) + (CW+1)'(push) - (CW+1)'(consume));
        end else begin
            if (push) wr_ptr_n = ptr_inc(wr_ptr);
            if (pop)  rd_ptr_n = ptr_inc(rd_ptr);
            cnt_n = cnt + CW'(push) - CW'(pop);
            if (drop_now) drop_cnt_n = drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            fifo_op[wr_ptr]    <= req_op_p0;
            fifo_a[wr_ptr]     <= req_a_p0;
            fifo_reg2[wr_ptr]  <= req_reg2_p0;
            fifo_waddr[wr_ptr] <= req_waddr_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_r        <= 1'b0;
            req_op_p0    <= '0;
            req_a_p0     <= '0;
            req_word_p0  <= '0;
            req_reg2_p0  <= '0;
            req_waddr_p0 <= '0;
            req_wr_p0    <= 1'b0;
            req_be_p0    <= '0;
            req_wdata_p0 <= '0;
            cnt          <= '0;
            drop_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_waddr     <= '0;
            wb_wdata     <= '0;
            exc_adel     <= 1'b0;
            exc_ades     <= 1'b0;
            exc_badvaddr <= '0;
        end else begin
            cnt      <= cnt_n;
            drop_cnt <= drop_cnt_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;

            if (flush)      req_r <= 1'b0;
            else if (issue) req_r <= 1'b1;
            else if (push)  req_r <= 1'b0;

            if (issue) begin
                req_op_p0    <= ex_op;
                req_a_p0     <= ex_addr[1:0];
                req_word_p0  <= ex_addr[31:2];
                req_reg2_p0  <= ex_reg2;
                req_waddr_p0 <= ex_waddr;
                req_wr_p0    <= is_store(ex_op);
                req_be_p0    <= store_be(ex_op, ex_addr[1:0]);
                req_wdata_p0 <= is_store(ex_op) ? store_data(ex_op, ex_addr[1:0], ex_reg2) : 32'h0;
            end

            exc_adel <= accept && is_load(ex_op) && misaligned(ex_op, ex_addr[1:0]);
            exc_ades <= accept && is_store(ex_op) && misaligned(ex_op, ex_addr[1:0]);
            if (accept && misaligned(ex_op, ex_addr[1:0])) exc_badvaddr <= ex_addr;

            // Writeback stage: registered result of the popped head
            wb_valid <= pop && !flush;
            if (pop && !flush) begin
                wb_we    <= is_load(head_op);
                wb_waddr <= fifo_waddr[rd_ptr];
                wb_wdata <= load_align(head_op, head_a, data_rdata, fifo_reg2[rd_ptr]);
            end else begin
                wb_we    <= 1'b0;
            end
        end
    end

    assign data_req   = req_r;
    assign data_wr    = req_wr_p0;
    assign data_be    = req_be_p0;
    assign data_addr  = {req_word_p0, 2'b00};
    assign data_wdata = req_wdata_p0;
    assign busy       = req_r || (cnt != '0) || (drop_cnt != '0);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, backpressure, flush, reset.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst, flush, ex_valid, ex_ready;
    logic [3:0]  ex_op;
    logic [31:0] ex_addr, ex_reg2;
    logic [4:0]  ex_waddr;
    logic        data_req, data_wr;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        exc_adel, exc_ades;
    logic [31:0] exc_badvaddr;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    mem_access_unit #(.DEPTH(2), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_addr(ex_addr),
        .ex_reg2(ex_reg2), .ex_waddr(ex_waddr),
        .data_req(data_req), .data_wr(data_wr), .data_be(data_be), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_badvaddr(exc_badvaddr), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] r,
                         input logic [4:0] wa);
        ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_reg2 = r; ex_waddr = wa;
    endtask

    // Full single-op load: accept, addr_ok one cycle after req, data_ok next, check wb
    task automatic run_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] r, input logic [31:0] d, input logic [31:0] exp);
        offer(op, addr, r, 5'd9);
        step();
        ex_valid = 1'b0;
        step();
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = d;
        step();
        data_data_ok = 1'b0;
        chk({tag, "_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, "_data"}, wb_wdata, exp);
        step();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_op = '0; ex_addr = '0; ex_reg2 = '0;
        ex_waddr = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_wb", 32'(wb_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ex_ready), 32'd1);

        // LB at 0x1003
        offer(4'd0, 32'h1003, 32'h0, 5'd5);
        step();
        ex_valid = 1'b0;
        chk("lb_req", 32'(data_req), 32'd1);
        chk("lb_wr", 32'(data_wr), 32'd0);
        chk("lb_be", 32'(data_be), 32'hF);
        chk("lb_addr", data_addr, 32'h1000);
        step();
        chk("lb_req_hold", 32'(data_req), 32'd1);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        chk("lb_req_drop", 32'(data_req), 32'd0);
        chk("lb_busy", 32'(busy), 32'd1);
        chk("lb_no_wb_yet", 32'(wb_valid), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h80FF_1234;
        step();
        data_data_ok = 1'b0;
        chk("lb_wb_valid", 32'(wb_valid), 32'd1);
        chk("lb_wb_we", 32'(wb_we), 32'd1);
        chk("lb_wb_waddr", 32'(wb_waddr), 32'd5);
        chk("lb_wb_data", wb_wdata, 32'hFFFF_FF80);
        step();
        chk("lb_wb_pulse", 32'(wb_valid), 32'd0);
        chk("lb_idle", 32'(busy), 32'd0);

        // SWR at 0x2002
        offer(4'd12, 32'h2002, 32'hAABB_CCDD, 5'd0);
        step();
        ex_valid = 1'b0;
        chk("swr_req", 32'(data_req), 32'd1);
        chk("swr_wr", 32'(data_wr), 32'd1);
        chk("swr_be", 32'(data_be), 32'hC);
        chk("swr_addr", data_addr, 32'h2000);
        chk("swr_wdata", data_wdata, 32'hCCDD_0000);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        step();
        data_data_ok = 1'b0;
        chk("swr_wb_valid", 32'(wb_valid), 32'd1);
        chk("swr_wb_we", 32'(wb_we), 32'd0);
        chk("swr_wb_data", wb_wdata, 32'h0);
        step();

        // Other store lane patterns
        offer(4'd8, 32'h5001, 32'h0000_00A5, 5'd0);
        step();
        ex_valid = 1'b0;
        chk("sb_be", 32'(data_be), 32'h2);
        chk("sb_wdata", data_wdata, 32'hA5A5_A5A5);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        offer(4'd11, 32'h5201, 32'h1122_3344, 5'd0);
        step();
        ex_valid = 1'b0;
        chk("swl_be", 32'(data_be), 32'h3);
        chk("swl_wdata", data_wdata, 32'h0000_1122);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        step();

        // Load alignment variants
        run_load("lh", 4'd2, 32'h6002, 32'h0, 32'h8001_1234, 32'hFFFF_8001);
        run_load("lbu", 4'd1, 32'h7001, 32'h0, 32'h1234_80FF, 32'h0000_0080);
        run_load("lwr", 4'd6, 32'h8003, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_33AA);

        // Misaligned and illegal ops
        offer(4'd4, 32'h3001, 32'h0, 5'd3);
        step();
        ex_valid = 1'b0;
        chk("lw_adel", 32'(exc_adel), 32'd1);
        chk("lw_ades", 32'(exc_ades), 32'd0);
        chk("lw_badv", exc_badvaddr, 32'h3001);
        chk("lw_noreq", 32'(data_req), 32'd0);
        step();
        chk("adel_pulse", 32'(exc_adel), 32'd0);
        offer(4'd9, 32'h4001, 32'h0, 5'd0);
        step();
        ex_valid = 1'b0;
        chk("sh_ades", 32'(exc_ades), 32'd1);
        chk("sh_badv", exc_badvaddr, 32'h4001);
        offer(4'd13, 32'h4000, 32'h0, 5'd0);
        step();
        ex_valid = 1'b0;
        chk("ill_noreq", 32'(data_req), 32'd0);
        chk("ill_noexc", 32'({exc_adel, exc_ades}), 32'd0);
        chk("ill_idle", 32'(busy), 32'd0);

        // Backpressure at DEPTH=2
        data_addr_ok = 1'b1;
        offer(4'd4, 32'h100, 32'h0, 5'd1);
        chk("bp_rdy0", 32'(ex_ready), 32'd1);
        step();
        offer(4'd4, 32'h104, 32'h0, 5'd2);
        chk("bp_rdy1", 32'(ex_ready), 32'd1);
        step();
        offer(4'd4, 32'h108, 32'h0, 5'd3);
        chk("bp_full_a", 32'(ex_ready), 32'd0);
        step();
        ex_valid = 1'b0;
        chk("bp_full_b", 32'(ex_ready), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
        step();
        chk("bp_rdy_back", 32'(ex_ready), 32'd1);
        chk("bp_wb1", wb_wdata, 32'h1111_1111);
        chk("bp_wb1_addr", 32'(wb_waddr), 32'd1);
        data_rdata = 32'h2222_2222;
        step();
        data_data_ok = 1'b0; data_addr_ok = 1'b0;
        chk("bp_wb2", wb_wdata, 32'h2222_2222);
        chk("bp_wb2_addr", 32'(wb_waddr), 32'd2);
        step();
        chk("bp_idle", 32'(busy), 32'd0);

        // Flush with two loads outstanding, then LWL after the stale responses
        data_addr_ok = 1'b1;
        offer(4'd4, 32'h200, 32'h0, 5'd4);
        step();
        offer(4'd4, 32'h204, 32'h0, 5'd4);
        step();
        ex_valid = 1'b0;
        step();
        data_addr_ok = 1'b0;
        flush = 1'b1;
        chk("fl_ready_in_flush", 32'(ex_ready), 32'd0);
        step();
        flush = 1'b0;
        chk("fl_wb0", 32'(wb_valid), 32'd0);
        chk("fl_full_drops", 32'(ex_ready), 32'd0);
        chk("fl_busy", 32'(busy), 32'd1);
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_0001;
        step();
        data_data_ok = 1'b0;
        chk("fl_drop1", 32'(wb_valid), 32'd0);
        offer(4'd5, 32'h0000_0001, 32'h1122_3344, 5'd7);
        chk("fl_rdy_lwl", 32'(ex_ready), 32'd1);
        step();
        ex_valid = 1'b0;
        chk("fl_lwl_req", 32'(data_req), 32'd1);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_0002;
        step();
        chk("fl_drop2", 32'(wb_valid), 32'd0);
        data_rdata = 32'h5566_7788;
        step();
        data_data_ok = 1'b0;
        chk("fl_lwl_valid", 32'(wb_valid), 32'd1);
        chk("fl_lwl_data", wb_wdata, 32'h7788_3344);
        chk("fl_lwl_waddr", 32'(wb_waddr), 32'd7);
        step();
        chk("fl_idle", 32'(busy), 32'd0);

        // Reset while a request is pending
        offer(4'd4, 32'h300, 32'h0, 5'd2);
        step();
        ex_valid = 1'b0;
        chk("rr_req", 32'(data_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rr_req0", 32'(data_req), 32'd0);
        chk("rr_busy0", 32'(busy), 32'd0);
        chk("rr_ready", 32'(ex_ready), 32'd1);
        chk("rr_outs", {data_be, 3'b0, data_wr, wb_valid, exc_adel, exc_ades, 1'b0, 16'h0, 4'h0},
            32'h0);
        data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
        step();
        data_data_ok = 1'b0;
        chk("rr_stray_ok", 32'(wb_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
